// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
// Optional I-type support is selected by REGFILE_CTRL_IMM_EN.
package regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

endpackage

// File: rtl/regfile_ctrl_instr_decode.sv
// Combinational RV32I ALU-instruction decoder for regfile_ctrl.
// REGFILE_CTRL_IMM_EN adds I-type decode and the imm/is_imm outputs.
module instr_decode
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] rs1,
  output logic [ADDR_WIDTH-1:0] rs2,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [2:0]            alu_ctrl,
`ifdef REGFILE_CTRL_IMM_EN
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  is_imm,
`endif
  output logic                  illegal
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       is_r_s;
  logic       is_i_s;
  logic       f3_ok_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign rs1      = ADDR_WIDTH'(instr[19:15]);
  assign rs2      = ADDR_WIDTH'(instr[24:20]);
  assign rd       = ADDR_WIDTH'(instr[11:7]);
  assign is_r_s   = (opcode_s == OP_R);

`ifdef REGFILE_CTRL_IMM_EN
  assign is_i_s = (opcode_s == OP_I);
  assign is_imm = is_i_s;
  assign imm    = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
`else
  logic unused_s;
  assign is_i_s   = 1'b0;
  assign unused_s = &{1'b0, instr[31], instr[29:25]};
`endif

  // funct3 to ALU op; SUB only exists for R-type with funct7[5] set
  always_comb begin
    alu_ctrl = ALU_ADD;
    f3_ok_s  = 1'b1;
    case (funct3_s)
      F3_ADD: begin
        if (is_r_s && instr[30]) begin
          alu_ctrl = ALU_SUB;
        end else begin
          alu_ctrl = ALU_ADD;
        end
      end
      F3_AND:  alu_ctrl = ALU_AND;
      F3_OR:   alu_ctrl = ALU_OR;
      F3_XOR:  alu_ctrl = ALU_XOR;
      F3_SLT:  alu_ctrl = ALU_SLT;
      default: begin
        alu_ctrl = ALU_ADD;
        f3_ok_s  = 1'b0;
      end
    endcase
  end

  assign illegal = !((is_r_s || is_i_s) && f3_ok_s);

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file access controller: accepts one ALU instruction, reads operands,
// hands them to the ALU and writes the result back. REGFILE_CTRL_IMM_EN enables I-type.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] rs1,
  output logic [ADDR_WIDTH-1:0] rs2,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic                  en,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] rd1,
  input  logic [DATA_WIDTH-1:0] rd2,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [2:0]            alu_ctrl,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res,
  output logic                  illegal
);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] rs1_r;
  logic [ADDR_WIDTH-1:0] rs2_r;
  logic [ADDR_WIDTH-1:0] rd_r;
  logic [2:0]            alu_ctrl_r;
  logic                  en_r;
  logic [DATA_WIDTH-1:0] din_r;
  logic                  op_valid_r;
  logic                  illegal_r;

  logic [ADDR_WIDTH-1:0] dec_rs1_s;
  logic [ADDR_WIDTH-1:0] dec_rs2_s;
  logic [ADDR_WIDTH-1:0] dec_rd_s;
  logic [2:0]            dec_alu_s;
  logic                  dec_illegal_s;

`ifdef REGFILE_CTRL_IMM_EN
  logic [DATA_WIDTH-1:0] dec_imm_s;
  logic                  dec_is_imm_s;
  logic [DATA_WIDTH-1:0] imm_r;
  logic                  is_imm_r;
`endif

  instr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_decode (
    .instr    (instr),
    .rs1      (dec_rs1_s),
    .rs2      (dec_rs2_s),
    .rd       (dec_rd_s),
    .alu_ctrl (dec_alu_s),
`ifdef REGFILE_CTRL_IMM_EN
    .imm      (dec_imm_s),
    .is_imm   (dec_is_imm_s),
`endif
    .illegal  (dec_illegal_s)
  );

  // Main control FSM with registered handshake, write-back and error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      rs1_r      <= {ADDR_WIDTH{1'b0}};
      rs2_r      <= {ADDR_WIDTH{1'b0}};
      rd_r       <= {ADDR_WIDTH{1'b0}};
      alu_ctrl_r <= 3'b000;
      en_r       <= 1'b0;
      din_r      <= {DATA_WIDTH{1'b0}};
      op_valid_r <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      illegal_r <= 1'b0;
      en_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (instr_valid) begin
            if (dec_illegal_s) begin
              illegal_r <= 1'b1;
            end else begin
              rs1_r      <= dec_rs1_s;
              rs2_r      <= dec_rs2_s;
              rd_r       <= dec_rd_s;
              alu_ctrl_r <= dec_alu_s;
              state_r    <= ST_READ;
            end
          end
        end
        ST_READ: begin
          op_valid_r <= 1'b1;
          state_r    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (op_ready) begin
            op_valid_r <= 1'b0;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            din_r   <= res;
            en_r    <= (rd_r != {ADDR_WIDTH{1'b0}});
            state_r <= ST_WB;
          end
        end
        ST_WB: begin
          state_r <= ST_IDLE;
        end
        default: begin
          op_valid_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef REGFILE_CTRL_IMM_EN
  // Immediate operand captured alongside the register fields on a legal accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_r    <= {DATA_WIDTH{1'b0}};
      is_imm_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && instr_valid && !dec_illegal_s) begin
        imm_r    <= dec_imm_s;
        is_imm_r <= dec_is_imm_s;
      end
    end
  end

  assign op_b = op_valid_r ? (is_imm_r ? imm_r : rd2) : {DATA_WIDTH{1'b0}};
`else
  assign op_b = op_valid_r ? rd2 : {DATA_WIDTH{1'b0}};
`endif

  // Regfile read data is itself registered and becomes valid exactly when ISSUE
  // starts, so operands pass through gated by the registered op_valid.
  assign op_a        = op_valid_r ? rd1 : {DATA_WIDTH{1'b0}};
  assign instr_ready = (state_r == ST_IDLE);
  assign rs1         = rs1_r;
  assign rs2         = rs2_r;
  assign rd          = rd_r;
  assign alu_ctrl    = alu_ctrl_r;
  assign en          = en_r;
  assign din         = din_r;
  assign op_valid    = op_valid_r;
  assign illegal     = illegal_r;

endmodule
